serial_frame_rx: RTL
====================

Name: serial_frame_rx

Overview:
- Parametrised serial-to-parallel frame receiver; successor to the fixed 11-bit deserialiser.
- Samples a single-wire line (idle high) and detects the start bit.
- Shifts in DATA_W data bits, then checks optional parity and the stop bit.
- Presents the word on a held output register with a valid/ack handshake, parity/frame error flags and overrun detection.
- Sits between the serial line front end (PS/2-style keyboard/device link) and the parallel consumer logic.

Parameters:
- DATA_W, 8, number of data bits per frame (2..16).
- PARITY_EN, 1, 1 = one parity bit follows the data; 0 = no parity bit.
- PARITY_ODD, 1, 1 = odd parity (data bits XOR parity bit == 1); 0 = even parity (== 0).
- LSB_FIRST, 0, 0 = first received data bit lands in oData[DATA_W-1]; 1 = first bit lands in oData[0].

Ports:
- Clock  input  1  block clock; all state updates on the falling edge.
- iReset  input  1  synchronous, active-high reset.
- iSampleEn  input  1  line is sampled only on Clock edges where this is 1 (bit-rate enable).
- i1b  input  1  serial line, idle 1.
- iAck  input  1  consumer acknowledges the held word; clears oValid.
- oData  output  DATA_W  last received data word.
- oValid  output  1  held high from word delivery until acknowledged.
- oParityErr  output  1  parity mismatch in the delivered frame (0 when PARITY_EN=0).
- oFrameErr  output  1  stop bit sampled as 0 in the delivered frame.
- oOverrun  output  1  sticky; a frame was delivered while oValid was still 1.
- oBusy  output  1  1 while the FSM is not in IDLE.

Behaviour:
- Clocking: single clock domain; all registers update on the falling edge of Clock.
- Reset: iReset=1 at an edge forces state IDLE, bit counter 0, shift register 0 and all outputs 0.
  - Reset overrides every other input.
  - A reset mid-frame discards the partial frame.
- Sample edge: a Clock edge with iSampleEn=1. Edges with iSampleEn=0 change nothing, except that iAck is still honoured.
- FSM states and transitions, evaluated on sample edges:
  - IDLE: i1b=0 → DATA with counter=0. i1b=1 → stay.
  - DATA: shift i1b into the shift register per LSB_FIRST; counter+1. After the DATA_W-th bit → PARITY if PARITY_EN, else STOP.
  - PARITY: capture i1b as the parity bit → STOP.
  - STOP: sample the stop bit and deliver the word on this same edge.
    - i1b=1 → IDLE.
    - i1b=0 → WAIT_IDLE.
  - WAIT_IDLE: stay until a sample edge sees i1b=1 → IDLE. A line stuck low never retriggers a frame.
- Delivery, on the STOP sample edge:
  - oData loads the shift-register contents.
  - oParityErr = PARITY_EN and (XOR of data bits and parity bit != PARITY_ODD).
  - oFrameErr = not i1b.
  - oValid is set to 1.
  - oOverrun is set to 1 if oValid was already 1 and iAck=0 on that edge.
  - A word with errors is still delivered, flags attached.
- Latency: outputs are visible immediately after the edge that samples the stop bit. With iSampleEn=1 continuously, the default frame completes 11 edges after the start-bit edge, counting the start-bit edge as edge 1.
- Handshake:
  - iAck=1 at an edge clears oValid, oParityErr, oFrameErr and oOverrun.
  - oData holds its value until the next delivery.
- Simultaneous iAck and delivery: the delivery wins. oValid stays 1, new data and flags load, and oOverrun is not set (the old word counts as consumed).
- iAck while oValid=0: no effect.
- Counter width: enough bits to hold DATA_W. The counter resets to 0 on every entry into DATA.

Test Plan:
- Default params, iSampleEn=1, line bits 0,1,0,1,0,0,1,0,1,1,1 (start, 0xA5 MSB-first, odd parity 1, stop) → on the 11th edge oData=0xA5, oValid=1, oParityErr=0, oFrameErr=0. iAck one edge later → oValid=0, oData stays 0xA5.
- Same frame with parity bit 0 → oData=0xA5, oValid=1, oParityErr=1, oFrameErr=0.
- Frame 0x3C with stop bit 0, then line held 0 for 6 edges → oFrameErr=1, oBusy=1 (WAIT_IDLE), no second delivery. Line to 1, then a clean frame 0x81 → oData=0x81, oFrameErr=0 after iAck.
- Two frames 0x12 then 0x34 with no iAck → oData=0x34, oOverrun=1. Repeat with iAck asserted on the second frame's stop edge → oOverrun=0, oValid=1, oData=0x34.
- iReset=1 after 4 data bits of a frame → all outputs 0, oBusy=0 next edge. Release reset, send 0xF0 → oData=0xF0 delivered cleanly.
- DATA_W=7, PARITY_EN=0, LSB_FIRST=1, iSampleEn high every 3rd edge, send 0x55 → delivery on the 9th sample edge, oData=0x55, other edges cause no state change.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: parametrised serial-to-parallel frame receiver for an idle-high single-wire
// link (PS/2-style). Frame: start bit (0), DATA_W data bits, optional parity bit, stop bit (1).
// All state updates on the falling edge of Clock; the line is sampled only when iSampleEn=1.
//
// Ports:
//   Clock       block clock, falling-edge active
//   iReset      synchronous active-high reset
//   iSampleEn   bit-rate enable; line is sampled only on edges where this is 1
//   i1b         serial line, idle 1
//   iAck        consumer acknowledge; clears oValid and the error/overrun flags
//   oData       last received word, held until the next delivery
//   oValid      word available, held until acknowledged
//   oParityErr  parity mismatch in the delivered frame
//   oFrameErr   stop bit sampled as 0 in the delivered frame
//   oOverrun    sticky; a word was delivered while the previous one was unacknowledged
//   oBusy       receiver is inside a frame or waiting for the line to return high
module serial_frame_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 1,
    parameter int unsigned LSB_FIRST  = 0
) (
    input  logic              Clock,
    input  logic              iReset,
    input  logic              iSampleEn,
    input  logic              i1b,
    input  logic              iAck,
    output logic [DATA_W-1:0] oData,
    output logic              oValid,
    output logic              oParityErr,
    output logic              oFrameErr,
    output logic              oOverrun,
    output logic              oBusy
);

    localparam int unsigned CntW   = $clog2(DATA_W + 1);
    localparam logic        OddBit = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;
    logic                deliver;
    logic                par_mismatch;

    // Parity over data plus the received parity bit; only meaningful on the stop edge.
    assign par_mismatch = (PARITY_EN != 0) && ((^shift_q ^ par_q) != OddBit);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        deliver = 1'b0;

        if (iSampleEn) begin
            unique case (state_q)
                StIdle: begin
                    if (!i1b) begin
                        state_d = StData;
                        cnt_d   = '0;
                    end
                end
                StData: begin
                    if (LSB_FIRST != 0) begin
                        shift_d = {i1b, shift_q[DATA_W-1:1]};
                    end else begin
                        shift_d = {shift_q[DATA_W-2:0], i1b};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(DATA_W - 1)) begin
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end
                end
                StParity: begin
                    par_d   = i1b;
                    state_d = StStop;
                end
                StStop: begin
                    deliver = 1'b1;
                    state_d = i1b ? StIdle : StWaitIdle;
                end
                StWaitIdle: begin
                    // A stuck-low line must see a high sample before a new start bit counts.
                    if (i1b) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Acknowledge is honoured regardless of iSampleEn.
        if (iAck) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end

        // Delivery wins over a simultaneous ack; the acked word counts as consumed.
        if (deliver) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = par_mismatch;
            ferr_d  = ~i1b;
            ovr_d   = iAck ? 1'b0 : (ovr_q | valid_q);
        end
    end

    always_ff @(negedge Clock) begin
        if (iReset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign oData      = data_q;
    assign oValid     = valid_q;
    assign oParityErr = perr_q;
    assign oFrameErr  = ferr_q;
    assign oOverrun   = ovr_q;
    assign oBusy      = (state_q != StIdle);

endmodule
